ddr2_line_burst_master: RTL and testbench

- Upstream master stage feeding the DDR2 controller+PHY local (Avalon-style) port.
- Converts whole cache-line requests from the Tiger memory hierarchy into fixed-length local bursts.
- Writes: buffers a full line, then streams it beat by beat.
- Reads: collects returned beats and hands the complete line back in one response handshake.
- Gates all traffic on local_init_done.

---
 rtl/ddr2_line_burst_master_if.sv | 48 ++++
 rtl/ddr2_line_burst_master.sv | 209 ++++++++++++++++++++
 tb/tb_ddr2_line_burst_master.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ddr2_line_burst_master_if.sv
// Line request/response port plus DDR2 local (Avalon-style) port of the line burst master.
// master = the burst master itself, slave = the surrounding hierarchy/controller view.
interface ddr2_line_burst_master_if #(
    parameter int BURST_LEN = 2,
    parameter int DATA_W    = 256,
    parameter int ADDR_W    = 25
);
    logic                            local_init_done;
    logic                            cmd_valid;
    logic                            cmd_ready;
    logic                            cmd_write;
    logic [ADDR_W-1:0]               cmd_addr;
    logic [DATA_W*BURST_LEN-1:0]     cmd_wdata;
    logic [DATA_W/8*BURST_LEN-1:0]   cmd_be;
    logic                            rsp_valid;
    logic                            rsp_ready;
    logic [DATA_W*BURST_LEN-1:0]     rsp_rdata;
    logic                            rsp_error;
    logic                            wr_done;
    logic [ADDR_W-1:0]               local_address;
    logic [6:0]                      local_size;
    logic                            local_burstbegin;
    logic                            local_read_req;
    logic                            local_write_req;
    logic [DATA_W-1:0]               local_wdata;
    logic [DATA_W/8-1:0]             local_be;
    logic                            local_ready;
    logic [DATA_W-1:0]               local_rdata;
    logic                            local_rdata_valid;
    logic                            local_rdata_error;
    logic                            unexpected_rdata;

    modport master (
        input  local_init_done, cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be,
               rsp_ready, local_ready, local_rdata, local_rdata_valid, local_rdata_error,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error, wr_done,
               local_address, local_size, local_burstbegin, local_read_req,
               local_write_req, local_wdata, local_be, unexpected_rdata
    );

    modport slave (
        output local_init_done, cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be,
               rsp_ready, local_ready, local_rdata, local_rdata_valid, local_rdata_error,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, wr_done,
               local_address, local_size, local_burstbegin, local_read_req,
               local_write_req, local_wdata, local_be, unexpected_rdata
    );
endinterface

// File: rtl/ddr2_line_burst_master.sv
// Cache-line to DDR2 local-burst master; all outputs registered, one line outstanding.
// Write beats hold until local_ready; read line held on rsp until rsp_ready; gated by local_init_done.
module ddr2_line_burst_master #(
    parameter int BURST_LEN = 2,
    parameter int DATA_W    = 256,
    parameter int ADDR_W    = 25
) (
    input  logic                      phy_clk,
    input  logic                      reset,
    ddr2_line_burst_master_if.master  bus
);
    localparam int                BE_W       = DATA_W / 8;
    localparam int                CNT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BURST_LEN - 1);
    localparam logic [6:0]        SIZE       = 7'(BURST_LEN);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {INIT, IDLE, WR_BEAT, RD_CMD, RD_WAIT, RESP} state_t;
    typedef logic [BURST_LEN-1:0][DATA_W-1:0] line_t;
    typedef logic [BURST_LEN-1:0][BE_W-1:0]   be_line_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    line_t             line_q, line_d;
    be_line_t          be_q, be_d;
    line_t             rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [6:0]        size_q, size_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_error_q, rsp_error_d;
    logic              wr_done_q, wr_done_d;
    logic              bb_q, bb_d;
    logic              rd_req_q, rd_req_d;
    logic              wr_req_q, wr_req_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   lbe_q, lbe_d;
    logic              unexp_q, unexp_d;
    state_t            after_line;

    always_ff @(posedge phy_clk or posedge reset) begin
        if (reset) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            line_q      <= '0;
            be_q        <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            wr_done_q   <= 1'b0;
            bb_q        <= 1'b0;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            wdata_q     <= '0;
            lbe_q       <= '0;
            unexp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
            be_q        <= be_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            wr_done_q   <= wr_done_d;
            bb_q        <= bb_d;
            rd_req_q    <= rd_req_d;
            wr_req_q    <= wr_req_d;
            wdata_q     <= wdata_d;
            lbe_q       <= lbe_d;
            unexp_q     <= unexp_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cnt_inc     = cnt_q + 1'b1;
        line_d      = line_q;
        be_d        = be_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        addr_d      = addr_q;
        size_d      = size_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_error_d = rsp_error_q;
        wr_done_d   = 1'b0;
        bb_d        = bb_q;
        rd_req_d    = rd_req_q;
        wr_req_d    = wr_req_q;
        wdata_d     = wdata_q;
        lbe_d       = lbe_q;
        unexp_d     = unexp_q | (bus.local_rdata_valid && (state_q != RD_WAIT));
        // A finished line falls back to INIT when calibration was lost meanwhile.
        after_line  = bus.local_init_done ? IDLE : INIT;

        case (state_q)
            INIT: begin
                if (bus.local_init_done) begin
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
                end
            end
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = bus.cmd_addr & ALIGN_MASK;
                    line_d      = bus.cmd_wdata;
                    be_d        = bus.cmd_be;
                    size_d      = SIZE;
                    bb_d        = 1'b1;
                    cnt_d       = '0;
                    if (bus.cmd_write) begin
                        state_d  = WR_BEAT;
                        wr_req_d = 1'b1;
                        wdata_d  = bus.cmd_wdata[DATA_W-1:0];
                        lbe_d    = bus.cmd_be[BE_W-1:0];
                    end else begin
                        state_d  = RD_CMD;
                        rd_req_d = 1'b1;
                    end
                end else if (!bus.local_init_done) begin
                    state_d     = INIT;
                    cmd_ready_d = 1'b0;
                end
            end
            WR_BEAT: begin
                if (bus.local_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d     = after_line;
                        cmd_ready_d = bus.local_init_done;
                        cnt_d       = '0;
                        wr_done_d   = 1'b1;
                        wr_req_d    = 1'b0;
                        bb_d        = 1'b0;
                        size_d      = '0;
                        wdata_d     = '0;
                        lbe_d       = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                        wdata_d = line_q[cnt_inc];
                        lbe_d   = be_q[cnt_inc];
                        bb_d    = 1'b0;
                    end
                end
            end
            RD_CMD: begin
                if (bus.local_ready) begin
                    state_d  = RD_WAIT;
                    rd_req_d = 1'b0;
                    bb_d     = 1'b0;
                    size_d   = '0;
                    cnt_d    = '0;
                end
            end
            RD_WAIT: begin
                if (bus.local_rdata_valid) begin
                    rdata_d[cnt_q] = bus.local_rdata;
                    err_d          = err_q | bus.local_rdata_error;
                    if (cnt_q == LAST_BEAT) begin
                        state_d     = RESP;
                        cnt_d       = '0;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = err_q | bus.local_rdata_error;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready && rsp_valid_q) begin
                    state_d     = after_line;
                    cmd_ready_d = bus.local_init_done;
                    rsp_valid_d = 1'b0;
                    rsp_error_d = 1'b0;
                    err_d       = 1'b0;
                end
            end
            default: begin
                state_d     = INIT;
                cmd_ready_d = 1'b0;
            end
        endcase
    end

    assign bus.cmd_ready        = cmd_ready_q;
    assign bus.rsp_valid        = rsp_valid_q;
    assign bus.rsp_rdata        = rdata_q;
    assign bus.rsp_error        = rsp_error_q;
    assign bus.wr_done          = wr_done_q;
    assign bus.local_address    = addr_q;
    assign bus.local_size       = size_q;
    assign bus.local_burstbegin = bb_q;
    assign bus.local_read_req   = rd_req_q;
    assign bus.local_write_req  = wr_req_q;
    assign bus.local_wdata      = wdata_q;
    assign bus.local_be         = lbe_q;
    assign bus.unexpected_rdata = unexp_q;
endmodule

// File: tb/tb_ddr2_line_burst_master.sv
// Directed bench for ddr2_line_burst_master: cycle table for write/read lines plus
// hand sequences for init gating, spurious read data, init loss and reset mid-burst.
module tb_ddr2_line_burst_master;
    localparam int BL = 2;
    localparam int DW = 256;
    localparam int AW = 25;

    logic phy_clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   xfers = 0;
    int   done_pulses = 0;

    ddr2_line_burst_master_if #(.BURST_LEN(BL), .DATA_W(DW), .ADDR_W(AW)) bus ();

    ddr2_line_burst_master #(.BURST_LEN(BL), .DATA_W(DW), .ADDR_W(AW)) dut (
        .phy_clk (phy_clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial phy_clk = 1'b0;
    always #5 phy_clk = ~phy_clk;

    always @(negedge phy_clk) begin
        if (bus.local_write_req && bus.local_ready) xfers++;
        if (bus.wr_done) done_pulses++;
    end

    typedef struct {
        logic       cv;
        logic       cw;
        logic       lr;
        logic       rv;
        logic [1:0] rsel;
        logic       rerr;
        logic       rr;
        logic [7:0] exp;
        int         beat;
    } vec_t;

    vec_t vecs[$];

    logic [BL-1:0][DW-1:0]   line;
    logic [BL-1:0][DW/8-1:0] be_line;
    logic [DW-1:0]           pat_aa, pat_55, pat_33, pat_44;

    function automatic vec_t mk(input logic cv, input logic cw, input logic lr, input logic rv,
                                input logic [1:0] rsel, input logic rerr, input logic rr,
                                input logic [7:0] exp, input int beat);
        vec_t v;
        v.cv = cv; v.cw = cw; v.lr = lr; v.rv = rv; v.rsel = rsel;
        v.rerr = rerr; v.rr = rr; v.exp = exp; v.beat = beat;
        return v;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge phy_clk);
        #1;
    endtask

    function automatic logic [7:0] ctl();
        return {bus.cmd_ready, bus.local_write_req, bus.local_read_req, bus.local_burstbegin,
                bus.wr_done, bus.rsp_valid, bus.rsp_error, bus.unexpected_rdata};
    endfunction

    function automatic logic [12:0] any_out();
        return {bus.cmd_ready, bus.rsp_valid, bus.rsp_error, bus.wr_done, |bus.local_address,
                |bus.local_size, bus.local_burstbegin, bus.local_read_req, bus.local_write_req,
                |bus.local_wdata, |bus.local_be, bus.unexpected_rdata, |bus.rsp_rdata};
    endfunction

    task automatic do_read(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           input logic e0, input logic e1, input logic exp_unexp);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0;
        tick();
        bus.cmd_valid = 1'b0;
        check("rd_req_raised", 512'(bus.local_read_req), 512'(1));
        bus.local_ready = 1'b1;
        tick();
        bus.local_ready = 1'b0;
        bus.local_rdata_valid = 1'b1; bus.local_rdata = d0; bus.local_rdata_error = e0;
        tick();
        bus.local_rdata = d1; bus.local_rdata_error = e1;
        tick();
        bus.local_rdata_valid = 1'b0; bus.local_rdata_error = 1'b0;
        check("rd_rsp_valid", 512'(bus.rsp_valid), 512'(1));
        check("rd_rsp_rdata", 512'(bus.rsp_rdata), {d1, d0});
        check("rd_rsp_error", 512'(bus.rsp_error), 512'(e0 | e1));
        check("rd_unexpected", 512'(bus.unexpected_rdata), 512'(exp_unexp));
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("rd_after_handshake", 512'({bus.rsp_valid, bus.cmd_ready}), 512'(2'b01));
    endtask

    initial begin
        bit gate_bad;
        bit seen;
        line    = {{8{32'h89AB_CDEF}}, {8{32'h0123_4567}}};
        be_line = {32'hF0F0_F0F0, 32'h0F0F_0F0F};
        pat_aa  = {32{8'hAA}};
        pat_55  = {32{8'h55}};
        pat_33  = {32{8'h33}};
        pat_44  = {32{8'h44}};

        reset = 1'b1;
        bus.local_init_done = 1'b0; bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0;
        bus.cmd_addr = 25'h000_0123; bus.cmd_wdata = line; bus.cmd_be = be_line;
        bus.rsp_ready = 1'b0; bus.local_ready = 1'b0; bus.local_rdata = '0;
        bus.local_rdata_valid = 1'b0; bus.local_rdata_error = 1'b0;
        repeat (2) @(posedge phy_clk);
        #1;
        check("reset_outputs", 512'(any_out()), 512'(0));
        reset = 1'b0;

        // Init gating: requests present but calibration not done.
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1;
        gate_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.cmd_ready || bus.local_write_req || bus.local_read_req) gate_bad = 1'b1;
        end
        check("init_gating", 512'(gate_bad), 512'(0));
        bus.cmd_valid = 1'b0;
        bus.local_init_done = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            tick();
            seen = bus.cmd_ready;
        end
        check("init_ready_within_2", 512'(seen), 512'(1));

        // exp = {cmd_ready, write_req, read_req, burstbegin, wr_done, rsp_valid, rsp_error, unexpected}
        // write, no stalls
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 8'b0101_0000, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 8'b0100_0000, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 8'b1000_1000, -1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 8'b1000_0000, -1));
        // write, beat 1 stalled three cycles
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8'b0101_0000, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 8'b0100_0000, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'b0100_0000, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'b0100_0000, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'b0100_0000, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 8'b1000_1000, -1));
        // read, command stalled, beats 4 cycles apart, error on beat 1, response held 5 cycles
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'b0011_0000, -1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'b0011_0000, -1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 8'b0000_0000, -1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 8'b0000_0000, -1));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'b0000_0000, -1));
        vecs.push_back(mk(0, 0, 0, 1, 2, 1, 0, 8'b0000_0110, -1));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'b0000_0110, -1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 8'b1000_0000, -1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'b1000_0000, -1));

        xfers = 0;
        done_pulses = 0;
        foreach (vecs[i]) begin
            bus.cmd_valid = vecs[i].cv;
            bus.cmd_write = vecs[i].cw;
            bus.local_ready = vecs[i].lr;
            bus.local_rdata_valid = vecs[i].rv;
            bus.local_rdata = (vecs[i].rsel == 2'd1) ? pat_aa : (vecs[i].rsel == 2'd2) ? pat_55 : '0;
            bus.local_rdata_error = vecs[i].rerr;
            bus.rsp_ready = vecs[i].rr;
            tick();
            check($sformatf("vec%0d_ctl", i), 512'(ctl()), 512'(vecs[i].exp));
            if (vecs[i].beat >= 0) begin
                check($sformatf("vec%0d_wdata", i), 512'(bus.local_wdata), 512'(line[vecs[i].beat]));
                check($sformatf("vec%0d_be", i), 512'(bus.local_be), 512'(be_line[vecs[i].beat]));
                check($sformatf("vec%0d_size", i), 512'(bus.local_size), 512'(7'd2));
            end
            if (vecs[i].exp[6] || vecs[i].exp[5])
                check($sformatf("vec%0d_addr", i), 512'(bus.local_address), 512'(25'h000_0122));
            if (vecs[i].exp[2])
                check($sformatf("vec%0d_rdata", i), 512'(bus.rsp_rdata), {pat_55, pat_aa});
        end
        bus.local_ready = 1'b0; bus.local_rdata_valid = 1'b0;
        bus.local_rdata_error = 1'b0; bus.rsp_ready = 1'b0;
        check("write_transfers", 512'(xfers), 512'(4));
        check("wr_done_pulses", 512'(done_pulses), 512'(2));

        // Spurious read data in IDLE.
        bus.local_rdata_valid = 1'b1; bus.local_rdata = {32{8'hFF}};
        tick();
        bus.local_rdata_valid = 1'b0;
        check("unexpected_set", 512'(bus.unexpected_rdata), 512'(1));
        repeat (3) tick();
        check("unexpected_sticky", 512'(bus.unexpected_rdata), 512'(1));
        do_read(pat_33, pat_44, 1'b0, 1'b0, 1'b1);

        // Loss of init in IDLE drops cmd_ready until it returns.
        bus.local_init_done = 1'b0;
        tick();
        check("init_loss_idle", 512'(bus.cmd_ready), 512'(0));
        bus.local_init_done = 1'b1;
        tick();
        check("init_regain", 512'(bus.cmd_ready), 512'(1));

        // Reset mid-write, after beat 0 transferred.
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.local_ready = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        check("pre_reset_beat1", 512'({bus.local_write_req, bus.local_burstbegin}), 512'(2'b10));
        #2 reset = 1'b1;
        #1 check("async_reset_outputs", 512'(any_out()), 512'(0));
        #2 reset = 1'b0;
        bus.local_ready = 1'b0;
        #1 check("post_reset_init", 512'(bus.cmd_ready), 512'(0));
        tick();
        check("post_reset_idle", 512'(bus.cmd_ready), 512'(1));
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        check("rewrite_beat0_ctl", 512'({bus.local_write_req, bus.local_burstbegin}), 512'(2'b11));
        check("rewrite_beat0_data", 512'(bus.local_wdata), 512'(line[0]));
        bus.local_ready = 1'b1;
        tick();
        check("rewrite_beat1_data", 512'(bus.local_wdata), 512'(line[1]));
        tick();
        bus.local_ready = 1'b0;
        check("rewrite_wr_done", 512'(bus.wr_done), 512'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
